id_ex_stage: RTL

- ID/EX pipeline register directly upstream of the EX stage.
- Captures the decoded instruction, register operands and control each cycle.
- Generates the sign-extended (snex) and zero-extended (ex) immediates.
- Pre-computes the registered forwarding selects that EX uses for its operand muxes, and detects load-use hazards, inserting a bubble plus a stall request.

---
 rtl/id_ex_stage.sv | 121 ++++++++++++
 1 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with immediate extension, forward selects and load-use stall
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [31:0] id_instr,
  input  logic [31:0] id_rs_data,
  input  logic [31:0] id_rt_data,
  input  logic        id_uses_rt,
  input  logic [1:0]  id_alu_src_b_ctrl,
  input  logic [1:0]  id_alu_op,
  input  logic        id_reg_write,
  input  logic        id_reg_dst,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_mem_to_reg,
  input  logic        mem_valid,
  input  logic        mem_reg_write,
  input  logic [4:0]  mem_dest,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [31:0] snex,
  output logic [31:0] ex,
  output logic [5:0]  F,
  output logic [1:0]  ALU_SrcA_fwd,
  output logic [1:0]  ALU_SrcB_fwd,
  output logic [1:0]  ALU_SrcB_ctrl,
  output logic [1:0]  ALUOp,
  output logic        ex_valid,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_mem_to_reg,
  output logic [4:0]  ex_dest
);

  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        hazard;
  logic        rs_mem, rs_wb, rt_mem, rt_wb;
  logic [1:0]  fwd_a, fwd_b;

  assign rs  = id_instr[25:21];
  assign rt  = id_instr[20:16];
  assign rd  = id_instr[15:11];
  assign imm = id_instr[15:0];

  // The instruction now in EX moves to MEM and the MEM occupant to WB when decode enters EX.
  always_comb begin
    hazard = ex_valid && ex_mem_read && (ex_dest != 5'd0) && id_valid &&
             ((ex_dest == rs) || (id_uses_rt && (ex_dest == rt)));
    rs_mem = ex_valid && ex_reg_write && (ex_dest != 5'd0) && (ex_dest == rs);
    rt_mem = ex_valid && ex_reg_write && (ex_dest != 5'd0) && (ex_dest == rt);
    rs_wb  = mem_valid && mem_reg_write && (mem_dest != 5'd0) && (mem_dest == rs);
    rt_wb  = mem_valid && mem_reg_write && (mem_dest != 5'd0) && (mem_dest == rt);
    fwd_a  = rs_mem ? 2'd2 : (rs_wb ? 2'd1 : 2'd0);
    fwd_b  = 2'd0;
    if ((id_alu_src_b_ctrl == 2'd0) && id_uses_rt)
      fwd_b = rt_mem ? 2'd2 : (rt_wb ? 2'd1 : 2'd0);
  end

  assign stall = hazard && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A             <= '0;
      B             <= '0;
      snex          <= '0;
      ex            <= '0;
      F             <= '0;
      ALU_SrcA_fwd  <= '0;
      ALU_SrcB_fwd  <= '0;
      ALU_SrcB_ctrl <= '0;
      ALUOp         <= '0;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_dest       <= '0;
    end else if (hold) begin
      // frozen: flush and stall are re-presented once hold drops
    end else if (flush || stall) begin
      A             <= '0;
      B             <= '0;
      snex          <= '0;
      ex            <= '0;
      F             <= '0;
      ALU_SrcA_fwd  <= '0;
      ALU_SrcB_fwd  <= '0;
      ALU_SrcB_ctrl <= '0;
      ALUOp         <= '0;
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      ex_dest       <= '0;
    end else begin
      A             <= id_rs_data;
      B             <= id_rt_data;
      snex          <= {{16{imm[15]}}, imm};
      ex            <= {16'b0, imm};
      F             <= id_instr[5:0];
      ALU_SrcA_fwd  <= fwd_a;
      ALU_SrcB_fwd  <= fwd_b;
      ALU_SrcB_ctrl <= id_alu_src_b_ctrl;
      ALUOp         <= id_alu_op;
      ex_valid      <= id_valid;
      ex_reg_write  <= id_valid && id_reg_write;
      ex_mem_read   <= id_valid && id_mem_read;
      ex_mem_write  <= id_valid && id_mem_write;
      ex_mem_to_reg <= id_valid && id_mem_to_reg;
      ex_dest       <= id_reg_dst ? rd : rt;
    end
  end

endmodule
